hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed-pipeline hazard unit.
- Tracks in-flight register writes (GPRs plus HI/LO as extra entries) with per-register busy bits and latency countdowns.
- Drives ID-stage stall and bypass-ready signals for any mix of fixed-latency (ALU, load, mult) and variable-latency (div) producers.
- Sits beside the decoder in ID: issue is reported on accept, writeback clears entries, a done pulse resolves variable-latency ops.

Parameters:
- NREG, 34, number of tracked registers (32 GPR + HI + LO); index 0 is hardwired zero.
- REGW, 6, register index width; must satisfy 2^REGW >= NREG.
- LATW, 3, countdown width. The value 2^LATW-1 (UNK) is reserved for "variable latency, wait for done".

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- hold  in  1  downstream pipeline frozen (e.g. stallE); freezes countdowns, blocks issue.
- flush  in  1  exception/redirect; clears all tracking state.
- issue_valid  in  1  ID holds a valid instruction this cycle.
- issue_wen  in  1  instruction writes issue_dst.
- issue_dst  in  REGW  destination index.
- issue_lat  in  LATW  cycles until result is on a bypass path; UNK = variable.
- src_a  in  REGW  first source index.
- src_b  in  REGW  second source index.
- use_a  in  1  src_a is actually read.
- use_b  in  1  src_b is actually read.
- done_valid  in  1  variable-latency producer finished.
- done_reg  in  REGW  register resolved by done_valid.
- wb_valid  in  1  architectural write this cycle.
- wb_reg  in  REGW  register written.
- stall  out  1  hold ID/IF this cycle.
- issue_ack  out  1  issue accepted this cycle.
- fwd_a  out  1  src_a must take the bypass value (producer in flight, result ready).
- fwd_b  out  1  src_b must take the bypass value.
- busy_count  out  REGW+1  number of busy entries.

Behaviour:

State:
- busy[i] (1 bit) and cnt[i] (LATW bits) for i in 1..NREG-1.
- Entry 0 is never busy.

Reset and flush:
- rst=1 at an edge clears all busy and cnt.
- flush=1 at an edge does the same, overriding every other input that cycle.
- Outputs are combinational from state plus inputs, so after reset: stall=0, fwd_a=0, fwd_b=0, busy_count=0, and issue_ack=issue_valid&~hold.

Source hazard:
- haz_x = use_x & src_x!=0 & busy[src_x] & cnt[src_x]!=0.
- fwd_x = use_x & src_x!=0 & busy[src_x] & cnt[src_x]==0.

Destination (WAW) hazard:
- waw = issue_wen & issue_dst!=0 & busy[issue_dst] & (cnt[issue_dst]==UNK | cnt[issue_dst]>issue_lat).
- This prevents an older write landing after a younger one.

Stall and issue:
- stall = issue_valid & (haz_a | haz_b | waw). stall does not include hold; the caller ORs the two.
- issue_ack = issue_valid & ~stall & ~hold.

Per-edge update (when not rst/flush), in priority order per entry:
1. Countdown: if ~hold, busy & cnt!=0 & cnt!=UNK, then cnt decrements by 1. UNK never decrements.
2. done_valid & busy[done_reg] & cnt==UNK sets cnt:=0. A done on a non-UNK or idle entry is ignored.
3. wb_valid & wb_reg!=0 clears busy[wb_reg].
4. issue_ack & issue_wen & issue_dst!=0 sets busy:=1, cnt:=issue_lat. This overrides steps 1–3 for the same index, so same-cycle writeback and reissue leaves the entry busy with the new latency.

Countdown semantics:
- issue_lat=0 means the result is forwardable from the next cycle.
- issue_lat=k means a dependent instruction stalls k cycles, then receives fwd=1.

Hold:
- Countdowns freeze.
- done and wb still apply, since wb and the divider run independently of the ID/EX freeze.

Counting:
- busy_count is popcount of busy, registered-state based.
- Never exceeds NREG-1.

Error case:
- Issue with issue_lat=UNK and no later done keeps the entry busy until wb or flush. This is legal; there is no timeout.

Test Plan:
1. Reset then idle: rst=1 one cycle → stall=0, fwd_a=fwd_b=0, busy_count=0. Then issue_valid=1, issue_wen=1, issue_dst=8, issue_lat=0 → issue_ack=1, next cycle busy_count=1.
2. Load-use: issue dst=9 lat=1; next cycle src_a=9, use_a=1 → stall=1 for 1 cycle, then stall=0, fwd_a=1. wb_valid, wb_reg=9 → fwd_a=0, busy_count=0.
3. Divider HI/LO: issue dst=32 lat=UNK, then src_a=32 for 20 cycles → stall=1 throughout, hold pulses have no effect. done_valid, done_reg=32 → next cycle stall=0, fwd_a=1.
4. WAW: dst=5 lat=UNK in flight; issue dst=5 lat=1 → stall=1, issue_ack=0 until done. With dst=5 at cnt=3, issue dst=5 lat=4 → stall=0.
5. Simultaneous events: wb_reg=7 and issue dst=7 lat=2 in the same cycle → busy[7] stays 1, src_a=7 stalls 2 cycles. src_a=0 with entry 0 issue → never stall, never fwd.
6. Hold and flush: dst=10 lat=3, hold=1 for 4 cycles → src_a=10 still stalls; release hold → fwd after 3 more cycles. flush=1 with 3 busy entries → busy_count=0 next cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage register scoreboard with per-entry latency countdowns.
// Drives stall / bypass-ready for fixed-latency and variable-latency (done-resolved) producers.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   hold              downstream frozen: countdowns freeze, issue blocked
//   flush             clears all tracking state, overrides everything
//   issue_*           instruction in ID: valid, writes dst, dst index, latency (UNK = variable)
//   src_a/b, use_a/b  source indices and read enables
//   done_valid/reg    variable-latency producer resolved
//   wb_valid/reg      architectural write clears the entry
//   stall             ID hazard (does not include hold)
//   issue_ack         issue accepted this cycle
//   fwd_a/b           source must take the bypass value
//   busy_count        number of busy entries

module hazard_scoreboard #(
  parameter int NREG = 34,
  parameter int REGW = 6,
  parameter int LATW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            flush,
  input  logic            issue_valid,
  input  logic            issue_wen,
  input  logic [REGW-1:0] issue_dst,
  input  logic [LATW-1:0] issue_lat,
  input  logic [REGW-1:0] src_a,
  input  logic [REGW-1:0] src_b,
  input  logic            use_a,
  input  logic            use_b,
  input  logic            done_valid,
  input  logic [REGW-1:0] done_reg,
  input  logic            wb_valid,
  input  logic [REGW-1:0] wb_reg,
  output logic            stall,
  output logic            issue_ack,
  output logic            fwd_a,
  output logic            fwd_b,
  output logic [REGW:0]   busy_count
);

  // All-ones countdown marks "variable latency, wait for done".
  localparam logic [LATW-1:0] UNK = '1;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [LATW-1:0] cnt_q [NREG];
  logic [LATW-1:0] cnt_d [NREG];

  logic            busy_a;
  logic            busy_b;
  logic            busy_w;
  logic [LATW-1:0] cnt_a;
  logic [LATW-1:0] cnt_b;
  logic [LATW-1:0] cnt_w;
  logic            haz_a;
  logic            haz_b;
  logic            waw;

  // Indices beyond NREG-1 match no entry and so read as idle.
  always_comb begin
    busy_a = 1'b0;
    busy_b = 1'b0;
    busy_w = 1'b0;
    cnt_a  = '0;
    cnt_b  = '0;
    cnt_w  = '0;
    for (int i = 0; i < NREG; i++) begin
      if (src_a == REGW'(i)) begin
        busy_a = busy_q[i];
        cnt_a  = cnt_q[i];
      end
      if (src_b == REGW'(i)) begin
        busy_b = busy_q[i];
        cnt_b  = cnt_q[i];
      end
      if (issue_dst == REGW'(i)) begin
        busy_w = busy_q[i];
        cnt_w  = cnt_q[i];
      end
    end
  end

  assign haz_a = use_a && (src_a != '0) && busy_a && (cnt_a != '0);
  assign haz_b = use_b && (src_b != '0) && busy_b && (cnt_b != '0);
  assign fwd_a = use_a && (src_a != '0) && busy_a && (cnt_a == '0);
  assign fwd_b = use_b && (src_b != '0) && busy_b && (cnt_b == '0);

  // An older write still pending past the new one's landing time would
  // overwrite the younger result.
  assign waw = issue_wen && (issue_dst != '0) && busy_w &&
               ((cnt_w == UNK) || (cnt_w > issue_lat));

  assign stall     = issue_valid && (haz_a || haz_b || waw);
  assign issue_ack = issue_valid && !stall && !hold;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    for (int i = 1; i < NREG; i++) begin
      if (!hold && busy_q[i] && (cnt_q[i] != '0) && (cnt_q[i] != UNK))
        cnt_d[i] = cnt_q[i] - LATW'(1);
      if (done_valid && (done_reg == REGW'(i)) && busy_q[i] &&
          (cnt_q[i] == UNK))
        cnt_d[i] = '0;
      if (wb_valid && (wb_reg == REGW'(i)))
        busy_d[i] = 1'b0;
      // A new issue wins over writeback of the same index.
      if (issue_ack && issue_wen && (issue_dst == REGW'(i))) begin
        busy_d[i] = 1'b1;
        cnt_d[i]  = issue_lat;
      end
    end
    busy_d[0] = 1'b0;
    cnt_d[0]  = '0;
    if (flush) begin
      busy_d = '0;
      for (int i = 0; i < NREG; i++)
        cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < NREG; i++)
        cnt_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    busy_count = '0;
    for (int i = 0; i < NREG; i++)
      busy_count = busy_count + {{REGW{1'b0}}, busy_q[i]};
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed table-driven bench for hazard_scoreboard.
// Inputs change at negedge, outputs are checked 1ns later.

module tb_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       hold;
  logic       flush;
  logic       issue_valid;
  logic       issue_wen;
  logic [5:0] issue_dst;
  logic [2:0] issue_lat;
  logic [5:0] src_a;
  logic [5:0] src_b;
  logic       use_a;
  logic       use_b;
  logic       done_valid;
  logic [5:0] done_reg;
  logic       wb_valid;
  logic [5:0] wb_reg;
  logic       stall;
  logic       issue_ack;
  logic       fwd_a;
  logic       fwd_b;
  logic [6:0] busy_count;

  int total;
  int passed;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_dst(issue_dst), .issue_lat(issue_lat),
    .src_a(src_a), .src_b(src_b), .use_a(use_a), .use_b(use_b),
    .done_valid(done_valid), .done_reg(done_reg),
    .wb_valid(wb_valid), .wb_reg(wb_reg),
    .stall(stall), .issue_ack(issue_ack),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .busy_count(busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, hold, flush, iv, wen;
    logic [5:0] dst;
    logic [2:0] lat;
    logic [5:0] sa;
    logic       ua;
    logic [5:0] sb;
    logic       ub, dv;
    logic [5:0] dreg;
    logic       wv;
    logic [5:0] wreg;
    logic       chk;
    logic       e_stall, e_ack, e_fa, e_fb;
    logic [6:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, h, f, iv, wen, input int dst, lat,
    input int sa, input logic ua, input int sb, input logic ub,
    input logic dv, input int dreg, input logic wv, input int wreg,
    input logic c, input logic st, ack, fa, fb, input int cnt);
    vec_t v;
    v.rst = r; v.hold = h; v.flush = f; v.iv = iv; v.wen = wen;
    v.dst = 6'(dst); v.lat = 3'(lat);
    v.sa = 6'(sa); v.ua = ua; v.sb = 6'(sb); v.ub = ub;
    v.dv = dv; v.dreg = 6'(dreg); v.wv = wv; v.wreg = 6'(wreg);
    v.chk = c; v.e_stall = st; v.e_ack = ack;
    v.e_fa = fa; v.e_fb = fb; v.e_cnt = 7'(cnt);
    return v;
  endfunction

  task automatic chk(input string n, input logic [6:0] got,
                     input logic [6:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d want %0d (t=%0t)", n, got, exp, $time);
  endtask

  task automatic idle();
    rst = 0; hold = 0; flush = 0;
    issue_valid = 0; issue_wen = 0; issue_dst = 0; issue_lat = 0;
    src_a = 0; src_b = 0; use_a = 0; use_b = 0;
    done_valid = 0; done_reg = 0; wb_valid = 0; wb_reg = 0;
  endtask

  task automatic iss(input int d, input int l);
    issue_valid = 1; issue_wen = 1;
    issue_dst = 6'(d); issue_lat = 3'(l);
  endtask

  initial begin
    total = 0;
    passed = 0;
    idle();

    //         r h f  iv w dst lat  sa ua sb ub  dv dr  wv wr  c  st ak fa fb cnt
    tbl.push_back(mk(1,0,0, 0,0,0,0,  0,0,0,0,  0,0,  0,0,  0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,0,  0,0,0,0,  0,0,  0,0,  1, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,8,0,  0,0,0,0,  0,0,  0,0,  1, 0,1,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,0,  8,1,0,0,  0,0,  0,0,  1, 0,0,1,0,1));
    tbl.push_back(mk(0,0,0, 0,0,0,0,  8,1,0,0,  0,0,  1,8,  1, 0,0,1,0,1));
    tbl.push_back(mk(0,0,0, 0,0,0,0,  8,1,0,0,  0,0,  0,0,  1, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,9,1,  0,0,0,0,  0,0,  0,0,  1, 0,1,0,0,0));
    tbl.push_back(mk(0,0,0, 1,0,0,0,  9,1,0,0,  0,0,  0,0,  1, 1,0,0,0,1));
    tbl.push_back(mk(0,0,0, 1,0,0,0,  9,1,0,0,  0,0,  0,0,  1, 0,1,1,0,1));
    tbl.push_back(mk(0,0,0, 0,0,0,0,  9,1,0,0,  0,0,  1,9,  1, 0,0,1,0,1));
    tbl.push_back(mk(0,0,0, 0,0,0,0,  9,1,0,0,  0,0,  0,0,  1, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,3,2,  0,0,0,0,  0,0,  0,0,  1, 0,1,0,0,0));
    tbl.push_back(mk(0,0,0, 1,0,0,0,  0,0,3,0,  0,0,  0,0,  1, 0,1,0,0,1));
    tbl.push_back(mk(0,0,0, 1,0,0,0,  0,0,3,1,  0,0,  0,0,  1, 1,0,0,0,1));
    tbl.push_back(mk(0,0,0, 1,0,0,0,  0,0,3,1,  0,0,  0,0,  1, 0,1,0,1,1));
    tbl.push_back(mk(0,0,0, 0,0,0,0,  0,0,0,0,  0,0,  1,3,  1, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0, 0,0,0,0,  0,0,0,0,  0,0,  0,0,  1, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,7,1,  0,0,0,0,  0,0,  0,0,  1, 0,1,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,0,  0,0,0,0,  0,0,  0,0,  1, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0, 1,1,7,2,  0,0,0,0,  0,0,  1,7,  1, 0,1,0,0,1));
    tbl.push_back(mk(0,0,0, 1,0,0,0,  7,1,0,0,  0,0,  0,0,  1, 1,0,0,0,1));
    tbl.push_back(mk(0,0,0, 1,0,0,0,  7,1,0,0,  0,0,  0,0,  1, 1,0,0,0,1));
    tbl.push_back(mk(0,0,0, 1,0,0,0,  7,1,0,0,  0,0,  0,0,  1, 0,1,1,0,1));
    tbl.push_back(mk(0,0,0, 0,0,0,0,  0,0,0,0,  0,0,  1,7,  1, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0, 1,1,0,3,  0,1,0,0,  0,0,  0,0,  1, 0,1,0,0,0));
    tbl.push_back(mk(0,0,0, 1,0,0,0,  0,1,0,1,  0,0,  0,0,  1, 0,1,0,0,0));
    tbl.push_back(mk(0,1,0, 1,1,4,0,  0,0,0,0,  0,0,  0,0,  1, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,0,  4,1,0,0,  0,0,  0,0,  1, 0,0,0,0,0));

    foreach (tbl[k]) begin
      @(negedge clk);
      rst = tbl[k].rst; hold = tbl[k].hold; flush = tbl[k].flush;
      issue_valid = tbl[k].iv; issue_wen = tbl[k].wen;
      issue_dst = tbl[k].dst; issue_lat = tbl[k].lat;
      src_a = tbl[k].sa; use_a = tbl[k].ua;
      src_b = tbl[k].sb; use_b = tbl[k].ub;
      done_valid = tbl[k].dv; done_reg = tbl[k].dreg;
      wb_valid = tbl[k].wv; wb_reg = tbl[k].wreg;
      #1;
      if (tbl[k].chk) begin
        chk($sformatf("v%0d stall", k), 7'(stall), 7'(tbl[k].e_stall));
        chk($sformatf("v%0d ack", k), 7'(issue_ack), 7'(tbl[k].e_ack));
        chk($sformatf("v%0d fwd_a", k), 7'(fwd_a), 7'(tbl[k].e_fa));
        chk($sformatf("v%0d fwd_b", k), 7'(fwd_b), 7'(tbl[k].e_fb));
        chk($sformatf("v%0d busy_count", k), busy_count, tbl[k].e_cnt);
      end
    end

    // Divider on HI: stalls through hold pulses until done.
    @(negedge clk); idle(); iss(32, 7); #1;
    chk("div_ack", 7'(issue_ack), 7'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); idle();
      issue_valid = 1; src_a = 32; use_a = 1; hold = (k % 3 == 0);
      #1;
      chk("div_stall", 7'(stall), 7'd1);
      chk("div_fwd", 7'(fwd_a), 7'd0);
    end
    @(negedge clk); idle();
    issue_valid = 1; src_a = 32; use_a = 1;
    done_valid = 1; done_reg = 32; hold = 1;
    #1; chk("div_done_cycle", 7'(stall), 7'd1);
    @(negedge clk); idle(); issue_valid = 1; src_a = 32; use_a = 1; #1;
    chk("div_after_stall", 7'(stall), 7'd0);
    chk("div_after_fwd", 7'(fwd_a), 7'd1);
    chk("div_after_ack", 7'(issue_ack), 7'd1);
    @(negedge clk); idle(); wb_valid = 1; wb_reg = 32;
    @(negedge clk); idle(); #1;
    chk("div_wb_count", busy_count, 7'd0);

    // Done on an idle entry and on a fixed-latency entry is ignored.
    @(negedge clk); idle(); iss(12, 3); done_valid = 1; done_reg = 20; #1;
    chk("dn_ack", 7'(issue_ack), 7'd1);
    @(negedge clk); idle(); hold = 1; done_valid = 1; done_reg = 12; #1;
    chk("dn_idle_count", busy_count, 7'd1);
    @(negedge clk); idle(); issue_valid = 1; src_a = 12; use_a = 1; #1;
    chk("dn_nonunk_stall", 7'(stall), 7'd1);
    @(negedge clk); idle(); wb_valid = 1; wb_reg = 12;

    // WAW against a variable-latency write, then latency ordering.
    @(negedge clk); idle(); iss(5, 7); #1;
    chk("waw_first_ack", 7'(issue_ack), 7'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle(); iss(5, 1); #1;
      chk("waw_unk_stall", 7'(stall), 7'd1);
      chk("waw_unk_ack", 7'(issue_ack), 7'd0);
    end
    @(negedge clk); idle(); iss(5, 1); done_valid = 1; done_reg = 5; #1;
    chk("waw_done_cycle", 7'(stall), 7'd1);
    @(negedge clk); idle(); iss(5, 1); #1;
    chk("waw_resolved_stall", 7'(stall), 7'd0);
    chk("waw_resolved_ack", 7'(issue_ack), 7'd1);
    @(negedge clk); idle(); iss(5, 4); #1;
    chk("waw_reissue_ack", 7'(issue_ack), 7'd1);
    @(negedge clk); idle();
    @(negedge clk); idle(); hold = 1; iss(5, 2); #1;
    chk("waw_gt_stall", 7'(stall), 7'd1);
    chk("waw_gt_ack", 7'(issue_ack), 7'd0);
    @(negedge clk); idle(); iss(5, 4); #1;
    chk("waw_c3_l4_stall", 7'(stall), 7'd0);
    chk("waw_c3_l4_ack", 7'(issue_ack), 7'd1);
    @(negedge clk); idle(); iss(5, 4); #1;
    chk("waw_eq_stall", 7'(stall), 7'd0);
    @(negedge clk); idle(); flush = 1;
    @(negedge clk); idle(); #1;
    chk("waw_flush_count", busy_count, 7'd0);

    // Hold freezes a countdown; release resumes it.
    @(negedge clk); idle(); iss(10, 3); #1;
    chk("hold_ack", 7'(issue_ack), 7'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle(); hold = 1;
      issue_valid = 1; src_a = 10; use_a = 1; #1;
      chk("hold_stall", 7'(stall), 7'd1);
      chk("hold_ack_blk", 7'(issue_ack), 7'd0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle(); issue_valid = 1; src_a = 10; use_a = 1; #1;
      chk("rel_stall", 7'(stall), 7'd1);
    end
    @(negedge clk); idle(); issue_valid = 1; src_a = 10; use_a = 1; #1;
    chk("rel_fwd_stall", 7'(stall), 7'd0);
    chk("rel_fwd", 7'(fwd_a), 7'd1);

    // Flush with three busy entries, overriding a same-cycle issue.
    @(negedge clk); idle(); iss(1, 7);
    @(negedge clk); idle(); iss(2, 0);
    @(negedge clk); idle(); #1;
    chk("fl_pre_count", busy_count, 7'd3);
    @(negedge clk); idle(); flush = 1; iss(11, 0);
    @(negedge clk); idle(); src_a = 10; use_a = 1; src_b = 2; use_b = 1; #1;
    chk("fl_count", busy_count, 7'd0);
    chk("fl_fwd_a", 7'(fwd_a), 7'd0);
    chk("fl_fwd_b", 7'(fwd_b), 7'd0);

    // Every tracked entry busy, then reset.
    for (int d = 0; d < 34; d++) begin
      @(negedge clk); idle(); iss(d, 0);
    end
    @(negedge clk); idle(); #1;
    chk("full_count", busy_count, 7'd33);
    @(negedge clk); idle(); rst = 1;
    @(negedge clk); idle(); src_a = 33; use_a = 1; #1;
    chk("rst_count", busy_count, 7'd0);
    chk("rst_fwd", 7'(fwd_a), 7'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
